// File: rtl/trans_packer_if.sv
// Transaction handshake between trans_packer and trans_validator.
// The packer presents a 128-bit word with valid; the validator returns a one-cycle ack.
`timescale 1ns/1ps
interface trans_packer_if;
    logic [127:0] data_o;
    logic         valid_o;
    logic         ack_i;

    modport master (output data_o, output valid_o, input ack_i);
    modport slave  (input data_o, input valid_o, output ack_i);
endinterface

// File: rtl/trans_packer.sv
// Assembles 16-byte big-endian frames from a byte stream into 128-bit words,
// queues them in a small FIFO and presents them on the validator handshake.
`timescale 1ns/1ps
module trans_packer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    input  logic                     in_sof,
    trans_packer_if.master           txn,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     frame_err_o,
    output logic                     ack_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

    typedef enum logic { IDLE, COLLECT } state_t;

    state_t             state;
    logic [3:0]         idx;
    logic [119:0]       shift_reg;
    logic [127:0]       mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [OCC_W-1:0]   count;

    logic               pop;
    logic               frame_done;
    logic               push;

    // A full FIFO still accepts a completing frame when the head leaves at the same edge.
    assign pop        = txn.ack_i & txn.valid_o;
    assign frame_done = in_valid & ~in_sof & (state == COLLECT) & (idx == 4'd15);
    assign push       = frame_done & ((count != FULL) | pop);

    assign txn.valid_o = (count != '0);
    assign txn.data_o  = txn.valid_o ? mem[rd_ptr] : '0;
    assign count_o     = count;

    // NOTE: the byte shifter and FIFO storage carry no reset; an empty count masks their contents.
    always_ff @(posedge clk) begin
        if (in_valid)
            shift_reg <= {shift_reg[111:0], in_data};
        if (push)
            mem[wr_ptr] <= {shift_reg, in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            drop_cnt_o  <= '0;
            frame_err_o <= 1'b0;
            ack_err_o   <= 1'b0;
        end else begin
            if (in_valid) begin
                if (in_sof) begin
                    if (state == COLLECT)
                        frame_err_o <= 1'b1;
                    state <= COLLECT;
                    idx   <= 4'd1;
                end else if (state == IDLE) begin
                    frame_err_o <= 1'b1;
                end else if (idx == 4'd15) begin
                    state <= IDLE;
                    idx   <= '0;
                end else begin
                    idx <= idx + 4'd1;
                end
            end

            if (frame_done && !push && (drop_cnt_o != '1))
                drop_cnt_o <= drop_cnt_o + 1'b1;

            if (txn.ack_i && !txn.valid_o)
                ack_err_o <= 1'b1;

            // Power-of-two depth lets both pointers wrap by plain overflow.
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_trans_packer.sv
// Self-checking bench for trans_packer: directed scenarios plus a randomized run
// against a queue-based frame/FIFO reference model.
`timescale 1ns/1ps
module tb_trans_packer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_sof;
    logic [CW-1:0]     count_o;
    logic [CNT_W-1:0]  drop_cnt_o;
    logic              frame_err_o;
    logic              ack_err_o;

    trans_packer_if txn_bus ();

    trans_packer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .txn         (txn_bus),
        .count_o     (count_o),
        .drop_cnt_o  (drop_cnt_o),
        .frame_err_o (frame_err_o),
        .ack_err_o   (ack_err_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: collected bytes of the open frame and the queue of words.
    logic [127:0] m_fifo [$];
    logic [7:0]   m_bytes [$];
    bit           m_in_frame;
    int           m_drop;
    bit           m_ferr;
    bit           m_aerr;

    function automatic logic [127:0] m_head();
        return (m_fifo.size() != 0) ? m_fifo[0] : 128'd0;
    endfunction

    function automatic logic [127:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_clear();
        m_fifo.delete();
        m_bytes.delete();
        m_in_frame = 0;
        m_drop     = 0;
        m_ferr     = 0;
        m_aerr     = 0;
    endtask

    // One clock: drive inputs, advance the model, sample after the edge at the falling edge.
    task automatic step(input logic [7:0] d, input logic v, input logic s, input logic a);
        int           occ;
        bit           pop;
        logic [127:0] w;
        in_data       = d;
        in_valid      = v;
        in_sof        = s;
        txn_bus.ack_i = a;
        occ = m_fifo.size();
        pop = a && (occ > 0);
        if (a && occ == 0)
            m_aerr = 1;
        if (pop)
            void'(m_fifo.pop_front());
        if (v) begin
            if (s) begin
                if (m_in_frame)
                    m_ferr = 1;
                m_bytes.delete();
                m_bytes.push_back(d);
                m_in_frame = 1;
            end else if (!m_in_frame) begin
                m_ferr = 1;
            end else begin
                m_bytes.push_back(d);
                if (m_bytes.size() == 16) begin
                    w = '0;
                    for (int i = 0; i < 16; i++)
                        w[127-8*i -: 8] = m_bytes[i];
                    m_bytes.delete();
                    m_in_frame = 0;
                    if (occ < DEPTH || pop)
                        m_fifo.push_back(w);
                    else if (m_drop < (2**CNT_W - 1))
                        m_drop++;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        in_valid      = 1'b0;
        in_sof        = 1'b0;
        txn_bus.ack_i = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input logic [127:0] w, input bit ack_last);
        for (int i = 0; i < 16; i++)
            step(w[127-8*i -: 8], 1'b1, i == 0, (i == 15) && ack_last);
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        in_data       = '0;
        in_valid      = 1'b0;
        in_sof        = 1'b0;
        txn_bus.ack_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++; if (txn_bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", txn_bus.valid_o); end
        n_cmp++; if (txn_bus.data_o !== 128'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", txn_bus.data_o); end
        n_cmp++; if (count_o !== '0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_cmp++; if (drop_cnt_o !== '0) begin n_bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); end
        n_cmp++; if ({frame_err_o, ack_err_o} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b want 00", {frame_err_o, ack_err_o}); end
    endtask

    task automatic test_single_frame();
        logic [127:0] w;
        w = 128'h0102030405060708090A0B0C0D0E0F10;
        apply_reset();
        send_frame(w, 1'b0);
        n_cmp++; if (txn_bus.valid_o !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", txn_bus.valid_o); end
        n_cmp++; if (txn_bus.data_o !== w) begin n_bad++; $display("FAIL single_data: got %h want %h", txn_bus.data_o, w); end
        n_cmp++; if (count_o !== CW'(1)) begin n_bad++; $display("FAIL single_count: got %0d want 1", count_o); end
    endtask

    task automatic test_single_ack();
        step(8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (txn_bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL ack_valid: got %b want 0", txn_bus.valid_o); end
        n_cmp++; if (count_o !== '0) begin n_bad++; $display("FAIL ack_count: got %0d want 0", count_o); end
        n_cmp++; if (ack_err_o !== 1'b0) begin n_bad++; $display("FAIL ack_no_err: got %b want 0", ack_err_o); end
    endtask

    task automatic test_overflow();
        logic [127:0] f [5];
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            f[k] = rand_word();
            send_frame(f[k], 1'b0);
        end
        n_cmp++; if (count_o !== CW'(4)) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", count_o); end
        n_cmp++; if (drop_cnt_o !== CNT_W'(1)) begin n_bad++; $display("FAIL ovf_drop: got %0d want 1", drop_cnt_o); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (txn_bus.data_o !== f[k]) begin n_bad++; $display("FAIL ovf_order%0d: got %h want %h", k, txn_bus.data_o, f[k]); end
            step(8'h00, 1'b0, 1'b0, 1'b1);
            idle(4);
        end
        n_cmp++; if (txn_bus.valid_o !== 1'b0) begin n_bad++; $display("FAIL ovf_drained: got %b want 0", txn_bus.valid_o); end
    endtask

    task automatic test_full_push_pop();
        logic [127:0] f [5];
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            f[k] = rand_word();
            send_frame(f[k], k == 4);
        end
        n_cmp++; if (drop_cnt_o !== '0) begin n_bad++; $display("FAIL fullpp_drop: got %0d want 0", drop_cnt_o); end
        n_cmp++; if (count_o !== CW'(4)) begin n_bad++; $display("FAIL fullpp_count: got %0d want 4", count_o); end
        for (int k = 1; k < 5; k++) begin
            n_cmp++; if (txn_bus.data_o !== f[k]) begin n_bad++; $display("FAIL fullpp_order%0d: got %h want %h", k, txn_bus.data_o, f[k]); end
            step(8'h00, 1'b0, 1'b0, 1'b1);
            idle(4);
        end
        n_cmp++; if (count_o !== '0) begin n_bad++; $display("FAIL fullpp_empty: got %0d want 0", count_o); end
    endtask

    task automatic test_resync();
        logic [127:0] w_old, w_new;
        apply_reset();
        w_old = rand_word();
        w_new = rand_word();
        for (int i = 0; i < 6; i++)
            step(w_old[127-8*i -: 8], 1'b1, i == 0, 1'b0);
        send_frame(w_new, 1'b0);
        idle(3);
        n_cmp++; if (frame_err_o !== 1'b1) begin n_bad++; $display("FAIL resync_err: got %b want 1", frame_err_o); end
        n_cmp++; if (count_o !== CW'(1)) begin n_bad++; $display("FAIL resync_count: got %0d want 1", count_o); end
        n_cmp++; if (txn_bus.data_o !== w_new) begin n_bad++; $display("FAIL resync_data: got %h want %h", txn_bus.data_o, w_new); end
        apply_reset();
        step(8'hA5, 1'b1, 1'b0, 1'b0);
        n_cmp++; if (frame_err_o !== 1'b1) begin n_bad++; $display("FAIL stray_err: got %b want 1", frame_err_o); end
        n_cmp++; if (count_o !== '0) begin n_bad++; $display("FAIL stray_count: got %0d want 0", count_o); end
    endtask

    task automatic test_ack_err();
        apply_reset();
        step(8'h00, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (ack_err_o !== 1'b1) begin n_bad++; $display("FAIL ackerr_flag: got %b want 1", ack_err_o); end
        n_cmp++; if (count_o !== '0) begin n_bad++; $display("FAIL ackerr_count: got %0d want 0", count_o); end
        idle(2);
        n_cmp++; if (ack_err_o !== 1'b1) begin n_bad++; $display("FAIL ackerr_sticky: got %b want 1", ack_err_o); end
    endtask

    task automatic test_reset_mid_frame();
        logic [127:0] w;
        apply_reset();
        send_frame(rand_word(), 1'b0);
        send_frame(rand_word(), 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b1);
        w = rand_word();
        for (int i = 0; i < 5; i++)
            step(w[127-8*i -: 8], 1'b1, i == 0, 1'b0);
        n_cmp++; if (count_o !== CW'(1)) begin n_bad++; $display("FAIL midrst_pre: got %0d want 1", count_o); end
        send_frame(rand_word(), 1'b0);
        n_cmp++; if ({ack_err_o, frame_err_o, count_o} !== {2'b01, CW'(2)}) begin n_bad++; $display("FAIL midrst_setup: got %b want 01_%0d", {ack_err_o, frame_err_o, count_o}, 2); end
        for (int i = 0; i < 5; i++)
            step(w[127-8*i -: 8], 1'b1, i == 0, 1'b0);
        apply_reset();
        n_cmp++; if ({txn_bus.valid_o, count_o, drop_cnt_o, frame_err_o, ack_err_o} !== '0) begin n_bad++; $display("FAIL midrst_state: valid %b count %0d drop %0d ferr %b aerr %b want all 0", txn_bus.valid_o, count_o, drop_cnt_o, frame_err_o, ack_err_o); end
        n_cmp++; if (txn_bus.data_o !== 128'd0) begin n_bad++; $display("FAIL midrst_data: got %h want 0", txn_bus.data_o); end
        w = rand_word();
        send_frame(w, 1'b0);
        n_cmp++; if (txn_bus.data_o !== w) begin n_bad++; $display("FAIL midrst_frame: got %h want %h", txn_bus.data_o, w); end
        n_cmp++; if ({count_o, frame_err_o} !== {CW'(1), 1'b0}) begin n_bad++; $display("FAIL midrst_count: got %0d/%b want 1/0", count_o, frame_err_o); end
    endtask

    task automatic test_random();
        logic       v, s, a;
        logic [7:0] d;
        apply_reset();
        for (int c = 0; c < 4000; c++) begin
            d = 8'($urandom);
            v = ($urandom_range(0, 3) != 0);
            s = m_in_frame ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 9) != 0);
            a = ($urandom_range(0, 5) == 0);
            step(d, v, s, a);
            n_cmp++; if (txn_bus.valid_o !== (m_fifo.size() != 0)) begin n_bad++; $display("FAIL rnd_valid c%0d: got %b want %b", c, txn_bus.valid_o, m_fifo.size() != 0); end
            n_cmp++; if (txn_bus.data_o !== m_head()) begin n_bad++; $display("FAIL rnd_data c%0d: got %h want %h", c, txn_bus.data_o, m_head()); end
            n_cmp++; if (count_o !== CW'(m_fifo.size())) begin n_bad++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, count_o, m_fifo.size()); end
            n_cmp++; if (drop_cnt_o !== CNT_W'(m_drop)) begin n_bad++; $display("FAIL rnd_drop c%0d: got %0d want %0d", c, drop_cnt_o, m_drop); end
            n_cmp++; if ({frame_err_o, ack_err_o} !== {m_ferr, m_aerr}) begin n_bad++; $display("FAIL rnd_errs c%0d: got %b want %b", c, {frame_err_o, ack_err_o}, {m_ferr, m_aerr}); end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        in_data       = '0;
        in_valid      = 1'b0;
        in_sof        = 1'b0;
        txn_bus.ack_i = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_single_ack();
        test_overflow();
        test_full_push_pop();
        test_resync();
        test_ack_err();
        test_reset_mid_frame();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
